// File: rtl/mem_loader_if.sv
// rtl/mem_loader_if.sv - program-word stream and shared-memory port bundle for mem_loader
interface mem_loader_if #(
   parameter int WORD_SIZE = 16,
   parameter int ADDR_SIZE = 16
);
   logic                 in_valid;
   logic [WORD_SIZE-1:0] in_data;
   logic                 in_ready;
   logic                 mem_r_en;
   logic                 mem_w_en;
   logic [ADDR_SIZE-1:0] mem_addr;
   logic [WORD_SIZE-1:0] mem_w_data;
   logic [WORD_SIZE-1:0] mem_r_data;

   // master is the loader: it drives the memory port and accepts the stream
   modport master (
      input  in_valid, in_data, mem_r_data,
      output in_ready, mem_r_en, mem_w_en, mem_addr, mem_w_data
   );

   modport slave (
      output in_valid, in_data, mem_r_data,
      input  in_ready, mem_r_en, mem_w_en, mem_addr, mem_w_data
   );
endinterface

// File: rtl/mem_loader.sv
// rtl/mem_loader.sv - streams a program image into shared memory, optionally verifies it
// by checksum readback, and holds the CPU halted until the image is good.
module mem_loader #(
   parameter int                   WORD_SIZE = 16,
   parameter int                   ADDR_SIZE = 16,
   parameter logic [ADDR_SIZE-1:0] BASE_ADDR = '0,
   parameter bit                   VERIFY    = 1'b1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [ADDR_SIZE-1:0] load_len,
   mem_loader_if.master         bus,
   output logic                 cpu_halt,
   output logic                 busy,
   output logic                 done,
   output logic                 error,
   output logic [ADDR_SIZE-1:0] words_loaded
);
   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_RDBK,
      S_CHECK,
      S_DONE,
      S_ERROR
   } state_t;

   localparam logic [ADDR_SIZE-1:0] ONE = 1;

   state_t               state, state_n;
   logic [ADDR_SIZE-1:0] len;
   logic [ADDR_SIZE-1:0] idx;
   logic [ADDR_SIZE-1:0] rd_idx;
   logic [WORD_SIZE-1:0] wsum;
   logic [WORD_SIZE-1:0] rsum;
   logic                 rd_pend;
   logic                 go;
   logic                 hs;
   logic                 rd_issue;

   assign bus.in_ready = (state == S_LOAD);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n  = state;
      go       = 1'b0;
      hs       = 1'b0;
      rd_issue = 1'b0;
      case (state)
         S_IDLE, S_DONE, S_ERROR: begin
            if (start) begin
               go      = 1'b1;
               state_n = (load_len == '0) ? S_DONE : S_LOAD;
            end
         end
         S_LOAD: begin
            hs = bus.in_valid;
            if (hs && (idx + ONE == len)) begin
               state_n = VERIFY ? S_RDBK : S_DONE;
            end
         end
         S_RDBK: begin
            rd_issue = (rd_idx != len);
            // leave only after the last read has been issued and its data folded into rsum
            if ((rd_idx == len) && !bus.mem_r_en && !rd_pend) begin
               state_n = S_CHECK;
            end
         end
         S_CHECK: begin
            state_n = (rsum == wsum) ? S_DONE : S_ERROR;
         end
         default: begin
            state_n = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         len            <= '0;
         idx            <= '0;
         rd_idx         <= '0;
         wsum           <= '0;
         rsum           <= '0;
         rd_pend        <= 1'b0;
         words_loaded   <= '0;
         bus.mem_w_en   <= 1'b0;
         bus.mem_r_en   <= 1'b0;
         bus.mem_addr   <= '0;
         bus.mem_w_data <= '0;
         cpu_halt       <= 1'b1;
         busy           <= 1'b0;
         done           <= 1'b0;
         error          <= 1'b0;
      end else begin
         bus.mem_w_en <= 1'b0;
         bus.mem_r_en <= 1'b0;
         // read data arrives the cycle after mem_r_en, so track one pending beat
         rd_pend <= bus.mem_r_en;
         if (rd_pend) begin
            rsum <= rsum + bus.mem_r_data;
         end

         if (hs) begin
            bus.mem_w_en   <= 1'b1;
            bus.mem_addr   <= BASE_ADDR + idx;
            bus.mem_w_data <= bus.in_data;
            wsum           <= wsum + bus.in_data;
            idx            <= idx + ONE;
            words_loaded   <= words_loaded + ONE;
         end

         if (rd_issue) begin
            bus.mem_r_en <= 1'b1;
            bus.mem_addr <= BASE_ADDR + rd_idx;
            rd_idx       <= rd_idx + ONE;
         end

         if (go) begin
            len          <= load_len;
            idx          <= '0;
            rd_idx       <= '0;
            wsum         <= '0;
            rsum         <= '0;
            words_loaded <= '0;
         end

         // status outputs are registered images of the state being entered
         done     <= (state_n == S_DONE);
         error    <= (state_n == S_ERROR);
         cpu_halt <= (state_n != S_DONE);
         busy     <= (state_n == S_LOAD) || (state_n == S_RDBK) || (state_n == S_CHECK);
      end
   end
endmodule

// File: tb/tb_mem_loader.sv
// tb/tb_mem_loader.sv - directed bench for mem_loader with a transaction-level memory model
module tb_mem_loader;
   typedef struct {
      logic [15:0] a;
      logic [15:0] d;
   } wr_t;

   logic        clk;
   logic        reset;
   logic        start, start2;
   logic [15:0] load_len;
   logic        in_valid;
   logic [15:0] in_data;
   logic        sel;
   logic        corrupt;
   logic        cpu_halt, busy, done, error;
   logic        cpu_halt2, busy2, done2, error2;
   logic [15:0] words_loaded, words_loaded2;
   logic        ready_sel;

   logic [15:0] mem0 [0:65535];
   logic [15:0] mem1 [0:65535];
   logic [15:0] words [0:15];
   wr_t         wq[$], wq2[$];
   logic [15:0] rq[$], rq2[$];
   int          n_chk, n_pass;

   mem_loader_if #(.WORD_SIZE(16), .ADDR_SIZE(16)) bi();
   mem_loader_if #(.WORD_SIZE(16), .ADDR_SIZE(16)) bi2();

   assign bi.in_valid  = in_valid & ~sel;
   assign bi2.in_valid = in_valid & sel;
   assign bi.in_data   = in_data;
   assign bi2.in_data  = in_data;
   assign ready_sel    = sel ? bi2.in_ready : bi.in_ready;

   mem_loader #(.WORD_SIZE(16), .ADDR_SIZE(16), .BASE_ADDR(16'h0000), .VERIFY(1'b1)) dut (
      .clk(clk), .reset(reset), .start(start), .load_len(load_len), .bus(bi.master),
      .cpu_halt(cpu_halt), .busy(busy), .done(done), .error(error), .words_loaded(words_loaded)
   );

   mem_loader #(.WORD_SIZE(16), .ADDR_SIZE(16), .BASE_ADDR(16'hFFFE), .VERIFY(1'b1)) dut2 (
      .clk(clk), .reset(reset), .start(start2), .load_len(load_len), .bus(bi2.master),
      .cpu_halt(cpu_halt2), .busy(busy2), .done(done2), .error(error2), .words_loaded(words_loaded2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (bi.mem_w_en) mem0[bi.mem_addr] <= bi.mem_w_data;
      if (bi.mem_r_en) bi.mem_r_data <= (corrupt && bi.mem_addr == 16'd2) ? 16'hDEAD : mem0[bi.mem_addr];
      if (bi2.mem_w_en) mem1[bi2.mem_addr] <= bi2.mem_w_data;
      if (bi2.mem_r_en) bi2.mem_r_data <= mem1[bi2.mem_addr];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // every memory access is matched in order against the precomputed transaction lists
   always @(negedge clk) begin
      wr_t t;
      logic [15:0] ra;
      if (reset) begin
         if (bi.mem_w_en | bi.mem_r_en) chk("rw_excl", 32'(bi.mem_w_en & bi.mem_r_en), 32'd0);
         if (bi.mem_w_en) begin
            chk("wr_expected", 32'(wq.size() != 0), 32'd1);
            if (wq.size() != 0) begin
               t = wq.pop_front();
               chk("wr_addr", 32'(bi.mem_addr), 32'(t.a));
               chk("wr_data", 32'(bi.mem_w_data), 32'(t.d));
            end
         end
         if (bi.mem_r_en) begin
            chk("rd_expected", 32'(rq.size() != 0), 32'd1);
            if (rq.size() != 0) begin
               ra = rq.pop_front();
               chk("rd_addr", 32'(bi.mem_addr), 32'(ra));
            end
         end
         if (bi2.mem_w_en | bi2.mem_r_en) chk("rw_excl2", 32'(bi2.mem_w_en & bi2.mem_r_en), 32'd0);
         if (bi2.mem_w_en) begin
            chk("wr2_expected", 32'(wq2.size() != 0), 32'd1);
            if (wq2.size() != 0) begin
               t = wq2.pop_front();
               chk("wr2_addr", 32'(bi2.mem_addr), 32'(t.a));
               chk("wr2_data", 32'(bi2.mem_w_data), 32'(t.d));
            end
         end
         if (bi2.mem_r_en) begin
            chk("rd2_expected", 32'(rq2.size() != 0), 32'd1);
            if (rq2.size() != 0) begin
               ra = rq2.pop_front();
               chk("rd2_addr", 32'(bi2.mem_addr), 32'(ra));
            end
         end
      end
   end

   task automatic setup(input logic s, input logic [15:0] base, input int n);
      for (int i = 0; i < n; i++) begin
         wr_t t;
         t.a = base + 16'(i);
         t.d = words[i];
         if (s) begin wq2.push_back(t); rq2.push_back(t.a); end
         else begin wq.push_back(t); rq.push_back(t.a); end
      end
   endtask

   function automatic logic [15:0] word_sum(input int n);
      logic [15:0] s = 16'd0;
      for (int i = 0; i < n; i++) s = s + words[i];
      return s;
   endfunction

   task automatic kick(input logic [15:0] n);
      @(negedge clk);
      load_len = n;
      if (sel) start2 = 1'b1;
      else start = 1'b1;
      @(posedge clk);
      #1;
      start  = 1'b0;
      start2 = 1'b0;
   endtask

   task automatic stream(input int n, input logic gaps, input logic poke);
      int   i = 0;
      int   g = 0;
      logic hs;
      while (i < n && g < 200) begin
         in_valid = gaps ? ((g % 2) == 0) : 1'b1;
         in_data  = words[i];
         if (poke && g == 2) begin
            start    = 1'b1;
            load_len = 16'd7;
         end
         @(negedge clk);
         hs = in_valid & ready_sel;
         @(posedge clk);
         #1;
         start = 1'b0;
         if (hs) i++;
         g++;
      end
      in_valid = 1'b0;
      chk("stream_count", 32'(i), 32'(n));
   endtask

   task automatic watch(input int limit, output int e);
      e = 0;
      for (int c = 1; c <= limit; c++) begin
         @(posedge clk);
         #1;
         if (sel ? (done2 | error2) : (done | error)) begin
            e = c;
            break;
         end
      end
      chk("finish_in_bound", 32'(e != 0), 32'd1);
   endtask

   initial begin
      int e;
      logic [15:0] ws, rs;
      n_chk = 0; n_pass = 0;
      reset = 1'b0; start = 1'b0; start2 = 1'b0; load_len = 16'd0;
      in_valid = 1'b0; in_data = 16'd0; sel = 1'b0; corrupt = 1'b0;
      for (int i = 0; i < 65536; i++) begin mem0[i] = 16'd0; mem1[i] = 16'd0; end

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_cpu_halt", 32'(cpu_halt), 32'd1);
      chk("rst_in_ready", 32'(bi.in_ready), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_error", 32'(error), 32'd0);
      chk("rst_w_en", 32'(bi.mem_w_en), 32'd0);
      chk("rst_r_en", 32'(bi.mem_r_en), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      reset = 1'b1;

      // basic gapless load of 10 words
      for (int i = 0; i < 10; i++) words[i] = 16'h1000 + 16'(i);
      setup(1'b0, 16'h0000, 10);
      kick(16'd10);
      fork
         stream(10, 1'b0, 1'b0);
         watch(200, e);
      join
      chk("basic_done_edge_lit", 32'(e), 32'd24);
      chk("basic_done_edge_model", 32'(e), 32'(2 * 10 + 4));
      chk("basic_done", 32'(done), 32'd1);
      chk("basic_error", 32'(error), 32'd0);
      chk("basic_cpu_halt", 32'(cpu_halt), 32'd0);
      chk("basic_busy", 32'(busy), 32'd0);
      chk("basic_words_loaded", 32'(words_loaded), 32'd10);
      chk("basic_wq_empty", 32'(wq.size()), 32'd0);
      chk("basic_rq_empty", 32'(rq.size()), 32'd0);
      for (int i = 0; i < 10; i++) chk("basic_mem", 32'(mem0[i]), 32'(words[i]));
      chk("basic_mem9_lit", 32'(mem0[9]), 32'h1009);

      // stalled stream, with a start pulse mid-load that must be ignored
      words[0] = 16'h2222; words[1] = 16'h3333; words[2] = 16'h4444; words[3] = 16'h5555;
      setup(1'b0, 16'h0000, 4);
      kick(16'd4);
      fork
         stream(4, 1'b1, 1'b1);
         watch(300, e);
      join
      chk("stall_done", 32'(done), 32'd1);
      chk("stall_words_loaded", 32'(words_loaded), 32'd4);
      chk("stall_wq_empty", 32'(wq.size()), 32'd0);
      chk("stall_rq_empty", 32'(rq.size()), 32'd0);
      for (int i = 0; i < 4; i++) chk("stall_mem", 32'(mem0[i]), 32'(words[i]));
      chk("stall_mem4_lit", 32'(mem0[4]), 32'h1004);

      // checksum mismatch: location 2 reads back as 0xDEAD
      for (int i = 0; i < 5; i++) words[i] = 16'h0011 * 16'(i + 1);
      ws = word_sum(5);
      rs = ws - words[2] + 16'hDEAD;
      setup(1'b0, 16'h0000, 5);
      corrupt = 1'b1;
      kick(16'd5);
      fork
         stream(5, 1'b0, 1'b0);
         watch(200, e);
      join
      corrupt = 1'b0;
      chk("vfail_error", 32'(error), 32'(ws != rs));
      chk("vfail_done", 32'(done), 32'd0);
      chk("vfail_cpu_halt", 32'(cpu_halt), 32'd1);
      chk("vfail_rq_empty", 32'(rq.size()), 32'd0);

      // zero-length restart from ERROR: DONE on the start edge, no memory access
      kick(16'd0);
      chk("len0_done", 32'(done), 32'd1);
      chk("len0_error_cleared", 32'(error), 32'd0);
      chk("len0_cpu_halt", 32'(cpu_halt), 32'd0);
      chk("len0_words_loaded", 32'(words_loaded), 32'd0);
      chk("len0_no_wr", 32'(bi.mem_w_en), 32'd0);
      chk("len0_no_rd", 32'(bi.mem_r_en), 32'd0);
      repeat (3) @(posedge clk);

      // address wrap on the instance based at 0xFFFE
      sel = 1'b1;
      words[0] = 16'h00A0; words[1] = 16'h00A1; words[2] = 16'h00A2;
      setup(1'b1, 16'hFFFE, 3);
      kick(16'd3);
      fork
         stream(3, 1'b0, 1'b0);
         watch(100, e);
      join
      chk("wrap_done_edge", 32'(e), 32'(2 * 3 + 4));
      chk("wrap_done", 32'(done2), 32'd1);
      chk("wrap_mem_fffe", 32'(mem1[16'hFFFE]), 32'h00A0);
      chk("wrap_mem_ffff", 32'(mem1[16'hFFFF]), 32'h00A1);
      chk("wrap_mem_0000", 32'(mem1[16'h0000]), 32'h00A2);
      chk("wrap_wq_empty", 32'(wq2.size()), 32'd0);
      sel = 1'b0;

      // reset after 5 of 10 words
      for (int i = 0; i < 10; i++) words[i] = 16'h5000 + 16'(i);
      setup(1'b0, 16'h0000, 10);
      kick(16'd10);
      stream(5, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      chk("abort_cpu_halt", 32'(cpu_halt), 32'd1);
      chk("abort_in_ready", 32'(bi.in_ready), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_words_loaded", 32'(words_loaded), 32'd0);
      chk("abort_wq_left", 32'(wq.size()), 32'd5);
      for (int i = 0; i < 5; i++) chk("abort_mem", 32'(mem0[i]), 32'(words[i]));
      chk("abort_mem5_lit", 32'(mem0[5]), 32'h1005);
      wq.delete();
      rq.delete();
      @(negedge clk);
      reset = 1'b1;
      repeat (3) @(posedge clk);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
